booth_csa_mul_seq: RTL and testbench
====================================

Name: booth_csa_mul_seq

Overview:
Sequential signed W×W multiplier controller that schedules a three-operand adder using radix-4 Booth recoding.
- Each iteration retires two Booth digits, one partial product per digit. Both partial products and the running accumulator go through one three-operand add, then a 4-bit arithmetic right shift.
- Sits beside the ALU and feeds the HI/LO product registers for MUL.
- Start/busy/done handshake toward the control unit.

Parameters:
- W, 32, operand width; must be a multiple of 4 and ≥8.
- ITER, W/4, iterations per multiply; derived, not overridable.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; operands sampled on the same edge.
- multiplicand  in  W  signed operand M.
- multiplier  in  W  signed operand Q.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; product valid from this cycle on.
- product_hi  out  W  upper half of the signed 2W-bit product.
- product_lo  out  W  lower half of the signed 2W-bit product.

Behaviour:
- Clock and reset: one clock, clock. Reset clear is asynchronous, active-high. Clear forces state IDLE, busy=0, done=0, product_hi=0, product_lo=0, and zeroes all internal registers.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures M, Q, appended bit q[-1]=0, acc=0, lo=0, cnt=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, one iteration per cycle, for digit pair k = cnt:
  - Digit d_j is taken from bits (q[2j+1], q[2j], q[2j-1]).
  - Encoding: 000→0, 001→+1, 010→+1, 011→+2, 100→−2, 101→−1, 110→−1, 111→0.
  - pp0 = d_{2k}·M, sign-extended to W+4 bits.
  - pp1 = (d_{2k+1}·M) << 2, sign-extended to W+4 bits.
  - Add: acc_next = acc + pp0 + pp1, computed modulo 2^(W+4) in one three-operand add. W+4 bits are provably sufficient; no overflow is possible.
  - Shift: {acc, lo} is arithmetic-right-shifted by 4. The low 4 bits of acc_next enter lo[W-1:W-4].
  - Q is logically right-shifted by 4 to bring up the next digit pair; cnt increments.
  - When cnt = ITER−1, the same edge loads product_hi = acc_shifted[W-1:0] and product_lo = lo_shifted, then goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation), so done and the new load share the edge.
  - Otherwise returns to IDLE.
- Latency: start sampled on edge 0; done high during the cycle following edge ITER (8 cycles for W=32). Throughput is one multiply per ITER+1 cycles back-to-back.
- busy:
  - Equals 1 exactly in RUN.
  - start while busy is ignored: operands are not resampled and no error is flagged.
- product_hi/lo hold their value until the next completed operation or clear. They are never partially updated.
- clear mid-RUN: abandons immediately; product registers are zeroed; no done pulse.
- Operand edge cases:
  - M = −2^(W−1) with d=−2 is handled inside the W+4-bit width.
  - Q = −2^(W−1) needs no extra digit, because the recoding is signed.

Decomposition:
- Shared package mul_pkg holds:
  - State enumeration for IDLE, RUN, DONE.
  - 3-bit Booth digit encoding constants: ZERO, P1, P2, N1, N2.
  - Constant for the accumulator guard width (4).
- One sub-module, booth_pp_sel: parameter W. It maps a 3-bit recode group plus M to a sign-extended W+4-bit partial product and is instantiated twice.
- The three-operand adder is a W+4-bit combinational instance inside the controller.

Test Plan:
- M=3, Q=5, start → done at cycle 8; product_hi=0x00000000, product_lo=0x0000000F; busy high cycles 1–8.
- M=0xFFFFFFFF, Q=0xFFFFFFFF (−1×−1) → product_hi=0x00000000, product_lo=0x00000001.
- M=0x80000000, Q=0x80000000 → product_hi=0x40000000, product_lo=0x00000000. Then M=0x7FFFFFFF, Q=0x80000000 → product_hi=0xC0000000, product_lo=0x80000000.
- start with 3×5, re-pulse start with 7×7 at cycle 4 → ignored; result 15. Then start asserted in the DONE cycle with 7×7 → accepted; done 8 cycles later with product_lo=0x31.
- start 0x12345678×0x9ABCDEF0, assert clear at cycle 4 for one cycle → busy, done and product regs drop to 0 asynchronously; no done pulse; next start runs normally.
- 1000 random signed pairs checked against a 2W-bit reference multiply; also every combination of M and Q drawn from {0, 1, −1, 0x7FFFFFFF, 0x80000000}.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] P1   = 3'd1;
  localparam logic [2:0] P2   = 3'd2;
  localparam logic [2:0] N1   = 3'd3;
  localparam logic [2:0] N2   = 3'd4;

  // Accumulator headroom above W bits; covers |2M| plus |2M|<<2 without overflow.
  localparam int unsigned GUARD = 4;

  function automatic logic [2:0] booth_digit(input logic [2:0] grp);
    logic [2:0] dig;
    case (grp)
      3'b001, 3'b010: dig = P1;
      3'b011:         dig = P2;
      3'b100:         dig = N2;
      3'b101, 3'b110: dig = N1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_csa_mul_seq_if.sv
// Start/busy/done handshake and operand/product bus between control unit and multiplier.
interface booth_csa_mul_seq_if #(parameter int unsigned W = 32);
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product_hi, product_lo);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product_hi, product_lo);
endinterface

// File: rtl/booth_pp_sel.sv
// Maps one radix-4 Booth recode group and M to a sign-extended W+GUARD-bit partial product.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [2:0]       grp_i,
  input  logic [W-1:0]     m_i,
  output logic [W+GUARD-1:0] pp_o
);
  localparam int unsigned PW = W + GUARD;

  logic [PW-1:0] m_ext;
  assign m_ext = {{GUARD{m_i[W-1]}}, m_i};

  always_comb begin
    pp_o = '0;
    case (booth_digit(grp_i))
      P1:      pp_o = m_ext;
      P2:      pp_o = m_ext << 1;
      N1:      pp_o = -m_ext;
      N2:      pp_o = -(m_ext << 1);
      default: pp_o = '0;
    endcase
  end
endmodule

// File: rtl/booth_csa_mul_seq.sv
// Sequential signed WxW multiplier: two Booth digits per cycle, one 3:2 CSA add, 4-bit shift.
module booth_csa_mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic              clock,
  input  logic              clear,
  booth_csa_mul_seq_if.slave mul_if
);
  localparam int unsigned ITER = W / 4;
  localparam int unsigned PW   = W + GUARD;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_e        state_q, state_d;
  logic [W-1:0]  m_q, m_d;
  logic [W:0]    q_q, q_d;          // bit 0 holds q[-1] of the current pair
  logic [PW-1:0] acc_q, acc_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  plo_q, plo_d;

  logic [PW-1:0]   pp0_c, pp1_raw_c, pp1_c;
  logic [PW-1:0]   csa_s_c, csa_c_c, sum_c;
  logic [PW+W-1:0] shifted_c;
  logic [PW-1:0]   acc_sh_c;
  logic [W-1:0]    lo_sh_c;

  booth_pp_sel #(.W(W)) u_pp0 (.grp_i(q_q[2:0]), .m_i(m_q), .pp_o(pp0_c));
  booth_pp_sel #(.W(W)) u_pp1 (.grp_i(q_q[4:2]), .m_i(m_q), .pp_o(pp1_raw_c));

  assign pp1_c = pp1_raw_c << 2;

  // Three-operand add: carry-save compress, then one carry-propagate add.
  assign csa_s_c = acc_q ^ pp0_c ^ pp1_c;
  assign csa_c_c = ((acc_q & pp0_c) | (acc_q & pp1_c) | (pp0_c & pp1_c)) << 1;
  assign sum_c   = csa_s_c + csa_c_c;

  assign shifted_c           = $signed({sum_c, lo_q}) >>> GUARD;
  assign {acc_sh_c, lo_sh_c} = shifted_c;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      plo_q   <= plo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    plo_d   = plo_q;

    case (state_q)
      ST_RUN: begin
        acc_d = acc_sh_c;
        lo_d  = lo_sh_c;
        q_d   = q_q >> 4;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          hi_d    = acc_sh_c[W-1:0];
          plo_d   = lo_sh_c;
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
        if (mul_if.start) begin
          m_d     = mul_if.multiplicand;
          q_d     = {mul_if.multiplier, 1'b0};
          acc_d   = '0;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign mul_if.busy       = busy_q;
  assign mul_if.done       = done_q;
  assign mul_if.product_hi = hi_q;
  assign mul_if.product_lo = plo_q;
endmodule

// File: tb/tb_booth_csa_mul_seq.sv
// Scoreboard bench for booth_csa_mul_seq against a plain 64-bit signed multiply.
module tb_booth_csa_mul_seq;
  localparam int unsigned W    = 32;
  localparam int unsigned ITER = W / 4;

  logic        clock;
  logic        clear;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  booth_csa_mul_seq_if #(.W(W)) mif ();
  booth_csa_mul_seq #(.W(W)) dut (.clock(clock), .clear(clear), .mul_if(mif));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [31:0] m, input logic [31:0] q);
    mif.start        = 1'b1;
    mif.multiplicand = m;
    mif.multiplier   = q;
    exp_q.push_back(ref_mul(m, q));
    @(negedge clock);
    mif.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_edges, input bit chk_busy);
    int edges;
    edges = 0;
    while (!mif.done && edges < 40) begin
      if (chk_busy) check("busy_in_run", 64'(mif.busy), 64'd1);
      @(negedge clock);
      edges++;
    end
    check("latency", 64'(edges), 64'(exp_edges));
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (!clear && mif.done) begin
        check("busy_low_in_done", 64'(mif.busy), 64'd0);
        check("done_has_expect", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("product", {mif.product_hi, mif.product_lo}, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corner [5];
    int          ndone;
    logic [31:0] rm, rq;
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    clear = 1'b0;
    mif.start = 1'b0;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    #3 clear = 1'b1;
    #1;
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    check("rst_product", {mif.product_hi, mif.product_lo}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    issue(32'd3, 32'd5);
    wait_done(ITER, 1'b1);
    check("prod_3x5", {mif.product_hi, mif.product_lo}, 64'h0000_0000_0000_000F);
    repeat (3) @(negedge clock);
    check("hold_after_done", {mif.product_hi, mif.product_lo}, 64'h0000_0000_0000_000F);
    check("idle_busy", 64'(mif.busy), 64'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(ITER, 1'b0);
    check("prod_m1xm1", {mif.product_hi, mif.product_lo}, 64'h0000_0000_0000_0001);
    issue(32'h8000_0000, 32'h8000_0000);
    wait_done(ITER, 1'b0);
    check("prod_minxmin", {mif.product_hi, mif.product_lo}, 64'h4000_0000_0000_0000);
    issue(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done(ITER, 1'b0);
    check("prod_maxxmin", {mif.product_hi, mif.product_lo}, 64'hC000_0000_8000_0000);
    @(negedge clock);

    // Re-pulse while busy is ignored, then back-to-back start in the DONE cycle.
    issue(32'd3, 32'd5);
    repeat (3) @(negedge clock);
    mif.start = 1'b1;
    mif.multiplicand = 32'd7;
    mif.multiplier   = 32'd7;
    @(negedge clock);
    mif.start = 1'b0;
    wait_done(ITER - 4, 1'b0);
    check("ignored_restart", {mif.product_hi, mif.product_lo}, 64'd15);
    issue(32'd7, 32'd7);
    wait_done(ITER, 1'b0);
    check("back_to_back", {mif.product_hi, mif.product_lo}, 64'h31);
    @(negedge clock);

    // Asynchronous clear mid-run.
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(negedge clock);
    #2 clear = 1'b1;
    #1;
    check("clr_busy", 64'(mif.busy), 64'd0);
    check("clr_done", 64'(mif.done), 64'd0);
    check("clr_product", {mif.product_hi, mif.product_lo}, 64'd0);
    exp_q.delete();
    @(negedge clock);
    clear = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clock);
      if (mif.done) ndone++;
    end
    check("no_done_after_clear", 64'(ndone), 64'd0);
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(ITER, 1'b0);

    foreach (corner[i]) begin
      foreach (corner[j]) begin
        issue(corner[i], corner[j]);
        wait_done(ITER, 1'b0);
      end
    end

    for (int n = 0; n < 1000; n++) begin
      rm = $urandom;
      rq = $urandom;
      if (n % 16 == 0) rm = corner[$urandom_range(4, 0)];
      if (n % 16 == 8) rq = corner[$urandom_range(4, 0)];
      issue(rm, rq);
      wait_done(ITER, 1'b0);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
